// File: rtl/calc3_req_arbiter.sv
// Front-end scheduler for calc3: per-port request FIFOs feeding a single
// round-robin issue register with valid/ready handshake toward the execution pipe.
module calc3_req_arbiter #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     req_cmd,
   input  logic [4*DW-1:0] req_data,
   input  logic [15:0]     req_d1,
   input  logic [15:0]     req_d2,
   input  logic [15:0]     req_r1,
   input  logic [7:0]      req_tag,
   output logic            iss_valid,
   input  logic            iss_ready,
   output logic [1:0]      iss_port,
   output logic [3:0]      iss_cmd,
   output logic [DW-1:0]   iss_data,
   output logic [3:0]      iss_d1,
   output logic [3:0]      iss_d2,
   output logic [3:0]      iss_r1,
   output logic [1:0]      iss_tag,
   output logic [3:0]      ovf_err,
   output logic            busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [DW-1:0] data;
      logic [3:0]    d1;
      logic [3:0]    d2;
      logic [3:0]    r1;
      logic [1:0]    tag;
   } entry_t;

   entry_t     head [4];
   logic [3:0] nonempty;
   logic [3:0] ovf_set;

   logic       load;
   logic       grant_valid;
   logic [1:0] grant_idx;

   logic       iss_valid_q;
   logic [1:0] iss_port_q;
   entry_t     iss_entry_q;
   logic [1:0] last_q;
   logic [3:0] ovf_q;

   assign load = !iss_valid_q || iss_ready;

   // Per-port FIFO; a full FIFO still accepts a push when it is popped on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_port
         entry_t        mem_q [DEPTH];
         entry_t        in_entry;
         logic [AW-1:0] wr_ptr_q;
         logic [AW-1:0] rd_ptr_q;
         logic [CW-1:0] count_q;
         logic [CW-1:0] count_d;
         logic          has_req;
         logic          full;
         logic          push;
         logic          pop;

         assign in_entry.cmd  = req_cmd[4*gi +: 4];
         assign in_entry.data = req_data[DW*gi +: DW];
         assign in_entry.d1   = req_d1[4*gi +: 4];
         assign in_entry.d2   = req_d2[4*gi +: 4];
         assign in_entry.r1   = req_r1[4*gi +: 4];
         assign in_entry.tag  = req_tag[2*gi +: 2];

         assign has_req      = in_entry.cmd != 4'd0;
         assign full         = count_q == CW'(DEPTH);
         assign pop          = load && grant_valid && (grant_idx == 2'(gi));
         assign push         = has_req && (!full || pop);
         assign ovf_set[gi]  = has_req && full && !pop;
         assign nonempty[gi] = count_q != '0;
         assign head[gi]     = mem_q[rd_ptr_q];

         always_comb begin
            count_d = count_q;
            if (push && !pop) begin
               count_d = count_q + CW'(1);
            end else if (pop && !push) begin
               count_d = count_q - CW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               count_q <= count_d;
               if (push) begin
                  wr_ptr_q <= wr_ptr_q + AW'(1);
               end
               if (pop) begin
                  rd_ptr_q <= rd_ptr_q + AW'(1);
               end
            end
         end

         // Storage carries no reset: occupancy gates every read.
         always_ff @(posedge clk) begin
            if (reset && push) begin
               mem_q[wr_ptr_q] <= in_entry;
            end
         end
      end
   endgenerate

   // Round-robin scan starting just after the last granted port.
   always_comb begin
      logic [1:0] idx;
      grant_valid = 1'b0;
      grant_idx   = last_q;
      idx         = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!grant_valid && nonempty[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         iss_valid_q <= 1'b0;
         iss_port_q  <= 2'd0;
         iss_entry_q <= '0;
         last_q      <= 2'd3;
         ovf_q       <= 4'd0;
      end else begin
         ovf_q <= ovf_q | ovf_set;
         if (load) begin
            iss_valid_q <= grant_valid;
            if (grant_valid) begin
               iss_entry_q <= head[grant_idx];
               iss_port_q  <= grant_idx;
               last_q      <= grant_idx;
            end
         end
      end
   end

   assign iss_valid = iss_valid_q;
   assign iss_port  = iss_port_q;
   assign iss_cmd   = iss_entry_q.cmd;
   assign iss_data  = iss_entry_q.data;
   assign iss_d1    = iss_entry_q.d1;
   assign iss_d2    = iss_entry_q.d2;
   assign iss_r1    = iss_entry_q.r1;
   assign iss_tag   = iss_entry_q.tag;
   assign ovf_err   = ovf_q;
   assign busy      = (|nonempty) || iss_valid_q;

endmodule

// File: tb/tb_calc3_req_arbiter.sv
// Directed bench for calc3_req_arbiter: reset, single issue, round-robin bursts,
// backpressure, overflow with pop-while-full, and reset mid-burst.
module tb_calc3_req_arbiter;

   logic         clk;
   logic         reset;
   logic [15:0]  req_cmd;
   logic [127:0] req_data;
   logic [15:0]  req_d1;
   logic [15:0]  req_d2;
   logic [15:0]  req_r1;
   logic [7:0]   req_tag;
   logic         iss_valid;
   logic         iss_ready;
   logic [1:0]   iss_port;
   logic [3:0]   iss_cmd;
   logic [31:0]  iss_data;
   logic [3:0]   iss_d1;
   logic [3:0]   iss_d2;
   logic [3:0]   iss_r1;
   logic [1:0]   iss_tag;
   logic [3:0]   ovf_err;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   calc3_req_arbiter #(.DEPTH(4), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_cmd   (req_cmd),
      .req_data  (req_data),
      .req_d1    (req_d1),
      .req_d2    (req_d2),
      .req_r1    (req_r1),
      .req_tag   (req_tag),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_port  (iss_port),
      .iss_cmd   (iss_cmd),
      .iss_data  (iss_data),
      .iss_d1    (iss_d1),
      .iss_d2    (iss_d2),
      .iss_r1    (iss_r1),
      .iss_tag   (iss_tag),
      .ovf_err   (ovf_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_cmd  = '0;
      req_data = '0;
      req_d1   = '0;
      req_d2   = '0;
      req_r1   = '0;
      req_tag  = '0;
   endtask

   task automatic set_req(input int p, input logic [3:0] cmd, input logic [31:0] data,
                          input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] r1,
                          input logic [1:0] tag);
      req_cmd[4*p +: 4]   = cmd;
      req_data[32*p +: 32] = data;
      req_d1[4*p +: 4]    = d1;
      req_d2[4*p +: 4]    = d2;
      req_r1[4*p +: 4]    = r1;
      req_tag[2*p +: 2]   = tag;
   endtask

   task automatic check_iss(input string tag, input logic [1:0] port, input logic [3:0] cmd,
                            input logic [31:0] data, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] r1, input logic [1:0] itag);
      check({tag, ".valid"}, 64'(iss_valid), 64'(1));
      check({tag, ".port"},  64'(iss_port),  64'(port));
      check({tag, ".cmd"},   64'(iss_cmd),   64'(cmd));
      check({tag, ".data"},  64'(iss_data),  64'(data));
      check({tag, ".d1"},    64'(iss_d1),    64'(d1));
      check({tag, ".d2"},    64'(iss_d2),    64'(d2));
      check({tag, ".r1"},    64'(iss_r1),    64'(r1));
      check({tag, ".tag"},   64'(iss_tag),   64'(itag));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_req();
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      iss_ready = 1'b0;
      clear_req();

      // 1: requests present during reset are ignored
      req_cmd  = 16'h1111;
      req_data = {4{32'hDEAD_BEEF}};
      tick();
      tick();
      clear_req();
      reset = 1'b1;
      check("t1.valid", 64'(iss_valid), 64'(0));
      check("t1.busy",  64'(busy),      64'(0));
      check("t1.ovf",   64'(ovf_err),   64'(0));
      check("t1.cmd",   64'(iss_cmd),   64'(0));
      check("t1.data",  64'(iss_data),  64'(0));
      check("t1.port",  64'(iss_port),  64'(0));
      iss_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1.idle_valid", 64'(iss_valid), 64'(0));
      end

      // 2: single request from port 2
      set_req(2, 4'd1, 32'h0000_0005, 4'd3, 4'd4, 4'd7, 2'd2);
      tick();
      clear_req();
      check("t2.nobypass", 64'(iss_valid), 64'(0));
      check("t2.busy_q",   64'(busy),      64'(1));
      tick();
      check_iss("t2.iss", 2'd2, 4'd1, 32'h5, 4'd3, 4'd4, 4'd7, 2'd2);
      tick();
      check("t2.after_valid", 64'(iss_valid), 64'(0));
      check("t2.after_busy",  64'(busy),      64'(0));

      // 3: two simultaneous four-port bursts, grants 0,1,2,3 each time
      do_reset();
      iss_ready = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         for (int p = 0; p < 4; p++) begin
            set_req(p, 4'(p + 1), 32'hA0 + 32'(p) + 32'(rep * 16), 4'(p), 4'(p + 4), 4'(p + 8), 2'(p));
         end
         tick();
         clear_req();
         for (int p = 0; p < 4; p++) begin
            tick();
            check_iss($sformatf("t3.r%0d.p%0d", rep, p), 2'(p), 4'(p + 1),
                      32'hA0 + 32'(p) + 32'(rep * 16), 4'(p), 4'(p + 4), 4'(p + 8), 2'(p));
         end
      end
      tick();
      check("t3.drained", 64'(iss_valid), 64'(0));

      // 4: backpressure holds port 0, then port 1 follows
      do_reset();
      iss_ready = 1'b0;
      set_req(0, 4'd2, 32'h11, 4'd1, 4'd2, 4'd3, 2'd1);
      set_req(1, 4'd3, 32'h22, 4'd4, 4'd5, 4'd6, 2'd2);
      tick();
      clear_req();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_iss($sformatf("t4.hold%0d", i), 2'd0, 4'd2, 32'h11, 4'd1, 4'd2, 4'd3, 2'd1);
      end
      iss_ready = 1'b1;
      tick();
      check_iss("t4.next", 2'd1, 4'd3, 32'h22, 4'd4, 4'd5, 4'd6, 2'd2);
      tick();
      check("t4.drained", 64'(iss_valid), 64'(0));
      check("t4.busy",    64'(busy),      64'(0));

      // 5: overflow on port 3, push accepted while popping a full FIFO
      do_reset();
      iss_ready = 1'b0;
      for (int r = 1; r <= 5; r++) begin
         set_req(3, 4'd4, 32'(r), 4'd1, 4'd2, 4'd3, 2'd3);
         tick();
      end
      check("t5.slot_r1",  64'(iss_data), 64'(1));
      check("t5.ovf_none", 64'(ovf_err),  64'(0));
      set_req(3, 4'd4, 32'd6, 4'd1, 4'd2, 4'd3, 2'd3);
      iss_ready = 1'b1;
      tick();
      check("t5.popfull_ovf", 64'(ovf_err),  64'(0));
      check("t5.slot_r2",     64'(iss_data), 64'(2));
      set_req(3, 4'd4, 32'd7, 4'd1, 4'd2, 4'd3, 2'd3);
      iss_ready = 1'b0;
      tick();
      clear_req();
      check("t5.ovf_set",  64'(ovf_err),  64'(4'b1000));
      check("t5.stall_r2", 64'(iss_data), 64'(2));
      iss_ready = 1'b1;
      for (int r = 3; r <= 6; r++) begin
         tick();
         check_iss($sformatf("t5.drain%0d", r), 2'd3, 4'd4, 32'(r), 4'd1, 4'd2, 4'd3, 2'd3);
      end
      tick();
      check("t5.no_r7",     64'(iss_valid), 64'(0));
      check("t5.ovf_stick", 64'(ovf_err),   64'(4'b1000));

      // 6: reset mid-burst discards queued and in-flight requests
      do_reset();
      check("t6.ovf_clr", 64'(ovf_err), 64'(0));
      iss_ready = 1'b0;
      for (int p = 0; p < 4; p++) begin
         set_req(p, 4'd5, 32'h60 + 32'(p), 4'd0, 4'd0, 4'd0, 2'(p));
      end
      tick();
      clear_req();
      tick();
      check("t6.pre_valid", 64'(iss_valid), 64'(1));
      check("t6.pre_busy",  64'(busy),      64'(1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t6.rst_valid", 64'(iss_valid), 64'(0));
      check("t6.rst_busy",  64'(busy),      64'(0));
      iss_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t6.quiet%0d", i), 64'(iss_valid), 64'(0));
      end
      check("t6.end_busy", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
